// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: valid/ready memory bus between the access unit (master) and memory (slave).
interface mem_access_unit_if;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_ready, bus_rvalid, bus_rdata
    );
    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_ready, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit that turns datapath memory requests into valid/ready bus
// transactions, with alignment checks, byte-lane steering, load extension and a timeout.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              stall,
    output logic              misalign,
    output logic              bus_err,
    mem_access_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
    state_t      state, state_d;
    logic [7:0]  cnt;
    logic [31:0] addr_q, wdata_q, rdata_q, lane, load_val;
    logic [2:0]  f3_q;
    logic        we_q, err_q;
    logic        access, illegal, start, expire, wr_ok, rd_ok;
    always_comb begin
        access   = memread | memwrite;
        illegal  = (funct3[1:0] == 2'b11) || (funct3[1:0] == 2'b01 && addr[0]) ||
                   (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        start    = state == IDLE && access && !illegal;
        misalign = state == IDLE && access && illegal;
        expire   = cnt == LAST;
        wr_ok    = state == REQ && we_q && bus.bus_ready;
        rd_ok    = state == RESP && bus.bus_rvalid;
        state_d  = state;
        case (state)
            IDLE: state_d = start ? REQ : IDLE;
            // a completing write or read response beats a simultaneous timeout
            REQ:  state_d = (wr_ok || expire) ? DONE : (bus.bus_ready ? RESP : REQ);
            RESP: state_d = (rd_ok || expire) ? DONE : RESP;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        stall         = start || state == REQ || state == RESP;
        bus_err       = state == DONE && err_q;
        readdata      = misalign ? 32'd0 : rdata_q;
        bus.bus_valid = state == REQ;
        bus.bus_we    = we_q;
        bus.bus_addr  = {addr_q[31:2], 2'b00};
        bus.bus_wdata = (f3_q[1:0] == 2'b00) ? {4{wdata_q[7:0]}} :
                        (f3_q[1:0] == 2'b01) ? {2{wdata_q[15:0]}} : wdata_q;
        bus.bus_wstrb = (f3_q[1:0] == 2'b00) ? 4'b0001 << addr_q[1:0] :
                        (f3_q[1:0] == 2'b01) ? 4'b0011 << addr_q[1:0] : 4'b1111;
        lane          = bus.bus_rdata >> {addr_q[1:0], 3'b000};
        load_val      = (f3_q[1:0] == 2'b00) ? {{24{lane[7] & ~f3_q[2]}}, lane[7:0]} :
                        (f3_q[1:0] == 2'b01) ? {{16{lane[15] & ~f3_q[2]}}, lane[15:0]} : lane;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 8'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            cnt <= (state == IDLE) ? 8'd0 : cnt + 8'd1;
            if (state_d == DONE && state != DONE) begin
                rdata_q <= rd_ok ? load_val : 32'd0;
                err_q   <= !(rd_ok || wr_ok);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (start) begin
            addr_q  <= addr;
            f3_q    <= funct3;
            wdata_q <= writedata;
            we_q    <= memwrite;
        end
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 TIMEOUT, 255, max cycles in REQ+RESP before an access is aborted (range 1..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 memread  in  1  load request from control, held stable while stall=1.
REQ-005 memwrite  in  1  store request from control, held stable while stall=1.
REQ-006 funct3  in  3  access size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use [1:0].
REQ-007 addr  in  32  byte address, the datapath ALU result.
REQ-008 writedata  in  32  store data, rs2 value, right-aligned.
REQ-009 readdata  out  32  extended load result, fed to the datapath result mux.
REQ-010 stall  out  1  freezes PC and register write while an access is in progress.
REQ-011 misalign  out  1  access rejected: misaligned address or size code 11.
REQ-012 bus_err  out  1  access aborted on timeout.
REQ-013 bus_valid  out  1  bus request valid.
REQ-014 bus_ready  in  1  bus request accepted.
REQ-015 bus_we  out  1  1 = write request.
REQ-016 bus_addr  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-017 bus_wdata  out  32  lane-replicated store data.
REQ-018 bus_wstrb  out  4  byte enables.
REQ-019 bus_rvalid  in  1  read response valid.
REQ-020 bus_rdata  in  32  read response word.

Function
REQ-021 FSM states: IDLE, REQ, RESP, DONE.
REQ-022 access = memread|memwrite; memwrite wins if both are set, and no read is issued.
REQ-023 Illegal when funct3[1:0]=11, half with addr[0]=1, or word with addr[1:0]!=00.
REQ-024 IDLE + illegal access: misalign=1 combinationally, stall=0, readdata=0, no bus activity, stay IDLE.
REQ-025 IDLE + legal access: stall=1 combinationally, latch addr/funct3/data/we, go to REQ next edge.
REQ-026 REQ: bus_valid=1 with latched fields held stable until bus_valid&bus_ready.
REQ-027 REQ handshake: write goes to DONE, read goes to RESP.
REQ-028 RESP: wait for bus_rvalid; bus_rvalid seen in IDLE, REQ or DONE is ignored.
REQ-029 RESP + bus_rvalid: select lane by addr[1:0], sign- or zero-extend per funct3, register into readdata, go to DONE.
REQ-030 Store lanes: SB wstrb=0001<<addr[1:0], data byte replicated x4; SH wstrb=0011<<addr[1:0], data half replicated x2; SW wstrb=1111.
REQ-031 Timeout counter (8-bit): clears on entry to REQ, increments each cycle in REQ/RESP; at TIMEOUT go to DONE with readdata=0, bus_err=1 for the DONE cycle.
REQ-032 DONE: stall=0 for exactly one cycle, readdata stable, then return to IDLE.
REQ-033 stall=1 exactly in IDLE-with-legal-access, REQ and RESP; minimum load/store latency 3 cycles (IDLE, REQ, DONE), loads +1 per RESP cycle.

Reset
REQ-034 rst=1 at an edge: state=IDLE, readdata=0, counter=0, and bus_valid, stall (when no access), misalign and bus_err are 0 next cycle.
REQ-035 Reset mid-REQ/RESP abandons the access; a later bus_rvalid for it is ignored.

Verification
REQ-036 LB, addr=0x103, bus_rdata=0x80FF_0000, rvalid 2 cycles after ready -> readdata=0xFFFF_FF80, stall high 4 cycles.
REQ-037 LHU, addr=0x102, bus_rdata=0xBEEF_1234 -> readdata=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-038 SB, addr=0x201, writedata=0x0000_00AB -> bus_addr=0x200, wstrb=0010, wdata=0xABAB_ABAB, bus_we=1.
REQ-039 LW, addr=0x102 -> misalign=1, stall=0, bus_valid never asserted.
REQ-040 LW, bus_ready tied 0, TIMEOUT=4 -> DONE after 4 REQ cycles, bus_err=1, readdata=0; rst during RESP -> IDLE, bus_valid=0 next cycle.
